dm_access_ctrl: RTL and testbench

//  Initiator side of the 12 KB byte-addressed data-memory port. Accepts one load/store request from the
//  CPU MEM stage via req/ready, checks alignment/range, sequences 1 or 2 DM accesses (the DM supports

---
 rtl/dm_access_ctrl_pkg.sv | 17 +
 rtl/dm_access_ctrl_if.sv | 15 +
 rtl/dm_access_ctrl_align_chk.sv | 25 ++
 rtl/dm_access_ctrl.sv | 92 +++++++++
 tb/tb_dm_access_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// mipslite_mem_pkg: shared op codes, FSM states and DM geometry for the data-memory access path
package mipslite_mem_pkg;
  localparam int DM_BYTES_DEF = 12288;
  localparam int AW_DEF = 14;
  localparam logic [2:0] OP_LW = 3'd0;
  localparam logic [2:0] OP_LB = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_LH = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SW = 3'd5;
  localparam logic [2:0] OP_SB = 3'd6;
  localparam logic [2:0] OP_SH = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_t;
  function automatic logic op_is_word(input logic [2:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: CPU MEM-stage request/response bus of the data-memory port
//   master (CPU): drives req/op/addr/wdata, receives ready/done/rdata/addr_err
//   slave (controller): the reverse
interface dm_access_ctrl_if #(parameter int AW = 14);
  logic req;
  logic [2:0] op;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic ready;
  logic done;
  logic [31:0] rdata;
  logic addr_err;
  modport master(output req, op, addr, wdata, input ready, done, rdata, addr_err);
  modport slave(input req, op, addr, wdata, output ready, done, rdata, addr_err);
endinterface

// File: rtl/dm_access_ctrl_align_chk.sv
// dm_align_chk: classifies an op and checks its alignment and DM range
//   i_op, i_addr -> o_legal, o_is_half, o_is_store
module dm_align_chk
  import mipslite_mem_pkg::*;
#(
  parameter int DM_BYTES = DM_BYTES_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [2:0]    i_op,
  input  logic [AW-1:0] i_addr,
  output logic          o_legal,
  output logic          o_is_half,
  output logic          o_is_store
);
  localparam logic [AW:0] LIM = (AW+1)'(DM_BYTES);
  logic [AW:0] w_a;
  always_comb begin
    // one extra bit so addr+1/addr+3 near the top cannot wrap past the limit
    w_a = {1'b0, i_addr};
    o_is_store = i_op == OP_SW || i_op == OP_SB || i_op == OP_SH;
    o_is_half = i_op == OP_LH || i_op == OP_LHU || i_op == OP_SH;
    o_legal = op_is_word(i_op) ? (i_addr[1:0] == 2'b00 && w_a + (AW+1)'(3) < LIM) :
              o_is_half ? (!i_addr[0] && w_a + (AW+1)'(1) < LIM) : w_a < LIM;
  end
endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences CPU loads/stores onto the word/byte-only data memory
//   clk, rst    : clock, async active-high reset
//   cpu         : request/response bus (slave side)
//   o_dm_addr, o_dm_din, o_dm_we, o_dm_byte_op : DM access outputs
//   i_dm_dout   : combinational DM read data (byte reads sign-extended)
module dm_access_ctrl
  import mipslite_mem_pkg::*;
#(
  parameter int DM_BYTES = DM_BYTES_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  dm_access_ctrl_if.slave     cpu,
  output logic [AW-1:0]       o_dm_addr,
  output logic [31:0]         o_dm_din,
  output logic                o_dm_we,
  output logic                o_dm_byte_op,
  input  logic [31:0]         i_dm_dout
);
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [AW-1:0] r_addr, r_dm_addr;
  logic [31:0] r_wdata, r_rdata, r_dm_din;
  logic [7:0] r_lo;
  logic r_err, r_half, r_store, r_byte_op;
  logic w_legal, w_is_half, w_is_store, w_ready, w_acc;
  dm_align_chk #(.DM_BYTES(DM_BYTES), .AW(AW)) u_chk (
    .i_op(cpu.op),
    .i_addr(cpu.addr),
    .o_legal(w_legal),
    .o_is_half(w_is_half),
    .o_is_store(w_is_store)
  );
  always_comb begin
    w_ready = r_state == S_IDLE || r_state == S_DONE;
    w_acc = cpu.req && w_ready;
    w_next = w_acc ? (w_legal ? S_ACC0 : S_DONE) :
             r_state == S_ACC0 ? (r_half ? S_ACC1 : S_DONE) :
             r_state == S_ACC1 ? S_DONE : S_IDLE;
  end
  assign cpu.ready = w_ready;
  assign cpu.done = r_state == S_DONE;
  assign cpu.rdata = r_rdata;
  assign cpu.addr_err = r_err;
  assign o_dm_addr = r_dm_addr;
  assign o_dm_din = r_dm_din;
  assign o_dm_byte_op = r_byte_op;
  assign o_dm_we = r_store && (r_state == S_ACC0 || r_state == S_ACC1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op <= OP_LW;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_lo <= '0;
      r_err <= 1'b0;
      r_half <= 1'b0;
      r_store <= 1'b0;
      r_dm_addr <= '0;
      r_dm_din <= '0;
      r_byte_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_op <= cpu.op;
        r_addr <= cpu.addr;
        r_wdata <= cpu.wdata;
        r_err <= !w_legal;
        r_half <= w_is_half;
        r_store <= w_is_store;
        if (w_legal) begin
          r_dm_addr <= cpu.addr;
          r_byte_op <= !op_is_word(cpu.op);
          if (w_is_store) r_dm_din <= op_is_word(cpu.op) ? cpu.wdata : {24'b0, cpu.wdata[7:0]};
        end
      end
      if (r_state == S_ACC0) begin
        if (r_half) begin
          r_lo <= i_dm_dout[7:0];
          r_dm_addr <= r_addr + 1'b1;
          if (r_store) r_dm_din <= {24'b0, r_wdata[15:8]};
        end else if (!r_store) begin
          r_rdata <= r_op == OP_LBU ? {24'b0, i_dm_dout[7:0]} : i_dm_dout;
        end
      end
      if (r_state == S_ACC1 && !r_store)
        r_rdata <= {(r_op == OP_LH && i_dm_dout[7]) ? 16'hFFFF : 16'h0000, i_dm_dout[7:0], r_lo};
    end
  end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed plus random load/store sequences checked against a byte-array model
module tb_dm_access_ctrl;
  import mipslite_mem_pkg::*;
  localparam int DMB = 12288;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [13:0] dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic dm_we, dm_byte_op;
  bit [7:0] dm_mem [DMB];
  bit [7:0] ref_mem [DMB];
  logic [31:0] exp_rdata = 32'h0;
  int checks = 0;
  int errors = 0;
  dm_access_ctrl_if #(.AW(14)) bus ();
  dm_access_ctrl #(.DM_BYTES(DMB), .AW(14)) dut (
    .clk(clk),
    .rst(rst),
    .cpu(bus),
    .o_dm_addr(dm_addr),
    .o_dm_din(dm_din),
    .o_dm_we(dm_we),
    .o_dm_byte_op(dm_byte_op),
    .i_dm_dout(dm_dout)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rd(input int i);
    return (i < DMB) ? dm_mem[i] : 8'h00;
  endfunction
  always_comb begin
    dm_dout = dm_byte_op ? {{24{rd(int'(dm_addr))[7]}}, rd(int'(dm_addr))} :
              {rd(int'(dm_addr) + 3), rd(int'(dm_addr) + 2), rd(int'(dm_addr) + 1), rd(int'(dm_addr))};
  end
  always @(posedge clk) begin
    if (dm_we) begin
      if (dm_byte_op) begin
        if (int'(dm_addr) < DMB) dm_mem[dm_addr] <= dm_din[7:0];
      end else if (int'(dm_addr) + 3 < DMB) begin
        dm_mem[dm_addr] <= dm_din[7:0];
        dm_mem[dm_addr + 14'd1] <= dm_din[15:8];
        dm_mem[dm_addr + 14'd2] <= dm_din[23:16];
        dm_mem[dm_addr + 14'd3] <= dm_din[31:24];
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_word(input logic [2:0] op);
    return op == 3'd0 || op == 3'd5;
  endfunction
  function automatic bit is_half(input logic [2:0] op);
    return op == 3'd3 || op == 3'd4 || op == 3'd7;
  endfunction
  function automatic bit is_legal(input logic [2:0] op, input int a);
    if (is_word(op)) return a % 4 == 0 && a + 3 < DMB;
    if (is_half(op)) return a % 2 == 0 && a + 1 < DMB;
    return a < DMB;
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
    int v;
    case (op)
      3'd0: v = ref_mem[a] + 256 * ref_mem[a+1] + 65536 * ref_mem[a+2] + 16777216 * ref_mem[a+3];
      3'd1: v = ref_mem[a] > 127 ? ref_mem[a] - 256 : ref_mem[a];
      3'd2: v = ref_mem[a];
      3'd3: begin
        v = ref_mem[a] + 256 * ref_mem[a+1];
        if (v > 32767) v = v - 65536;
      end
      default: v = ref_mem[a] + 256 * ref_mem[a+1];
    endcase
    return 32'(v);
  endfunction
  task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] wd);
    ref_mem[a] = wd[7:0];
    if (op != 3'd6) ref_mem[a+1] = wd[15:8];
    if (op == 3'd5) begin
      ref_mem[a+2] = wd[23:16];
      ref_mem[a+3] = wd[31:24];
    end
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_addr_err"}, bus.addr_err, 0);
    chk({tag, "_dm_addr"}, dm_addr, 0);
    chk({tag, "_dm_din"}, dm_din, 0);
    chk({tag, "_dm_we"}, dm_we, 0);
    chk({tag, "_dm_byte_op"}, dm_byte_op, 0);
  endtask
  // issue one request at a negedge; returns at the negedge where done is seen
  task automatic xact(input logic [2:0] op, input int a, input logic [31:0] wd, input bit hold);
    int lat, nwe, exp_lat, exp_we;
    bit legal, st;
    legal = is_legal(op, a);
    st = op >= 3'd5;
    exp_lat = !legal ? 1 : is_half(op) ? 3 : 2;
    exp_we = (legal && st) ? (is_half(op) ? 2 : 1) : 0;
    chk("ready_at_issue", bus.ready, 1);
    bus.req = 1'b1;
    bus.op = op;
    bus.addr = a[13:0];
    bus.wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req = 1'b0;
    lat = 1;
    nwe = 0;
    while (!bus.done && lat < 8) begin
      chk("ready_busy", bus.ready, 0);
      if (lat == 1) begin
        chk("acc0_dm_addr", dm_addr, a);
        chk("acc0_byte_op", dm_byte_op, !is_word(op));
      end
      if (dm_we) nwe++;
      @(negedge clk);
      lat++;
    end
    bus.req = 1'b0;
    if (legal && st) ref_store(op, a, wd);
    if (legal && !st) exp_rdata = ref_load(op, a);
    chk("done_latency", lat, exp_lat);
    chk("addr_err", bus.addr_err, !legal);
    chk("rdata", bus.rdata, exp_rdata);
    chk("we_cycles", nwe, exp_we);
    chk("we_in_done", dm_we, 0);
  endtask
  task automatic mem_cmp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) chk($sformatf("mem_%0h", i), dm_mem[i], ref_mem[i]);
  endtask
  initial begin
    int a, pick;
    logic [2:0] op;
    bus.req = 1'b0;
    bus.op = 3'd0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    xact(OP_SW, 'h010, 32'hDEADBEEF, 0);
    xact(OP_LW, 'h010, 32'h0, 0);
    chk("lw_deadbeef", bus.rdata, 32'hDEADBEEF);
    xact(OP_SB, 'h021, 32'h000000F3, 0);
    xact(OP_LB, 'h021, 32'h0, 0);
    chk("lb_f3", bus.rdata, 32'hFFFFFFF3);
    xact(OP_LBU, 'h021, 32'h0, 0);
    chk("lbu_f3", bus.rdata, 32'h000000F3);
    xact(OP_SH, 'h030, 32'h00008A5C, 0);
    xact(OP_LH, 'h030, 32'h0, 0);
    chk("lh_8a5c", bus.rdata, 32'hFFFF8A5C);
    xact(OP_LHU, 'h030, 32'h0, 0);
    chk("lhu_8a5c", bus.rdata, 32'h00008A5C);
    chk("byte_30", dm_mem['h30], 8'h5C);
    chk("byte_31", dm_mem['h31], 8'h8A);
    xact(OP_LW, 'h012, 32'h0, 0);
    xact(OP_SH, 'h031, 32'h0000FFFF, 0);
    xact(OP_SW, 'h2FFE, 32'hFFFFFFFF, 0);
    xact(OP_SW, 'h2FFC, 32'hCAFEF00D, 0);
    xact(OP_SW, 'h050, 32'h0BADF00D, 1);
    @(negedge clk);
    chk("hold_no_reaccept_done", bus.done, 0);
    chk("hold_no_reaccept_ready", bus.ready, 1);
    mem_cmp(0, 'h5F);
    mem_cmp(DMB - 8, DMB - 1);
    xact(OP_SB, 'h041, 32'h00000077, 0);
    bus.req = 1'b1;
    bus.op = OP_SH;
    bus.addr = 14'h040;
    bus.wdata = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    chk("acc1_we", dm_we, 1);
    chk("acc1_dm_addr", dm_addr, 'h41);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    ref_mem['h40] = 8'h34;
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_byte_40", dm_mem['h40], 8'h34);
    chk("rst_byte_41", dm_mem['h41], 8'h77);
    xact(OP_LW, 'h010, 32'h0, 0);
    chk("lw_after_rst", bus.rdata, 32'hDEADBEEF);
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 9));
      a = pick < 7 ? 256 + int'($urandom_range(0, 63)) :
          pick < 9 ? DMB - 8 + int'($urandom_range(0, 7)) : int'($urandom_range(DMB, 16383));
      xact(op, a, $urandom, n % 17 == 5);
      if (n % 17 == 5) @(negedge clk);
    end
    mem_cmp(0, 'h5F);
    mem_cmp('h100, 'h143);
    mem_cmp(DMB - 8, DMB - 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
